ofdm_tx_frame_serializer: RTL and testbench
===========================================

# ofdm_tx_frame_serializer

Parametrised ping-pong frame buffer and serializer at the head of the OFDM VLC transmit chain. It accepts one whole frame word from the PS-side register interface and streams it out LSB-first in OUT_W-bit beats to the subcarrier mapper. Valid/ready handshakes on both sides replace the free-running read pointer of the previous generation. Two banks let the next frame load while the current one drains.

## Interface
- FRAME_W, 224, frame width in bits; must be a multiple of OUT_W
- OUT_W, 1, bits per output beat (1 = BPSK/OOK, 2 = QPSK, 4 = 16-QAM)
- CNT_W, 16, width of the sent-frame counter
- BEATS (localparam) = FRAME_W/OUT_W; PTR_W (localparam) = clog2(BEATS), minimum 1
- clk  in  1  sole clock, rising edge
- nreset  in  1  asynchronous, active-low reset
- din  in  FRAME_W  frame word
- din_valid  in  1  frame word valid
- din_ready  out  1  at least one bank free; forced 0 while nreset low or flush high
- flush  in  1  synchronous clear of both banks and pointers
- dout  out  OUT_W  current beat = bank[rd_sel][rd_ptr*OUT_W +: OUT_W]
- dout_valid  out  1  read bank holds a frame
- dout_ready  in  1  downstream accepts beat
- dout_last  out  1  dout_valid and rd_ptr == BEATS-1
- dout_idx  out  PTR_W  beat index within the frame (rd_ptr)
- buff_full  out  1  both banks occupied
- buff_empty  out  1  both banks free
- frames_sent  out  CNT_W  frames fully drained, wraps modulo 2^CNT_W

## Operation
- State: two FRAME_W banks with full flags full[1:0], wr_sel, rd_sel, rd_ptr, frames_sent.
- Write: the input handshake fires when din_valid && din_ready. The frame is stored in bank[wr_sel], full[wr_sel] is set, and wr_sel toggles. din_ready = ~(full[0] & full[1]) & ~flush & nreset. It must not depend on din_valid.
- Read: dout_valid = full[rd_sel]. The output handshake fires when dout_valid && dout_ready.
  - Beat other than last: rd_ptr increments.
  - Last beat: rd_ptr returns to 0, full[rd_sel] clears, rd_sel toggles, frames_sent increments.
- Simultaneous write and last-beat read in the same cycle: both take effect. The write lands in the free bank. When both banks were full, din_ready was low, so no write occurs that cycle.
- dout, dout_valid, dout_last and dout_idx are decoded from registered state only. There is no combinational path from din or din_valid to any output. dout_ready reaches no output combinationally.
- dout holds its value and dout_valid stays high while dout_ready is low. Data must not change under stall.
- flush high takes priority over both handshakes in that cycle:
  - full[1:0] clear; wr_sel, rd_sel and rd_ptr go to 0.
  - frames_sent is unchanged.
  - A partially sent frame is dropped without dout_last.
- Mid-operation reset: everything returns to reset values immediately, asynchronously. A partial frame is lost.

## Timing
- Reset values: din_ready 0 while nreset low and 1 from the first edge after release; dout 0; dout_valid 0; dout_last 0; dout_idx 0; buff_full 0; buff_empty 1; frames_sent 0. Bank contents reset to 0.
- Load latency: a frame accepted on edge N into an empty buffer gives dout_valid = 1 after edge N, so beat 0 can transfer on edge N+1.
- Throughput: one beat per cycle with dout_ready held high. Back-to-back frames stream with no idle cycle between the last beat of frame k and beat 0 of frame k+1, provided frame k+1 was loaded earlier.
- Input side: at most 2 frames buffered. A third frame waits on din_ready, with no overflow path.
- flush asserted on edge N: dout_valid = 0 and buff_empty = 1 after edge N. din_ready returns the cycle flush deasserts.

## Test plan
- FRAME_W=224, OUT_W=1, din=0x...0001_8000_0000_0005, dout_ready=1 -> 224 beats. dout sequence is 1,0,1,0,... matching din LSB-first. dout_last only on beat 223. frames_sent=1. buff_empty=1 afterwards.
- OUT_W=2, two frames loaded back-to-back -> buff_full=1 and din_ready=0 after the second load. Third frame is held until the first frame's last beat. Then 224 contiguous beats with no dout_valid gap at the boundary.
- Random dout_ready (50% duty) -> dout stable while stalled, no beat lost or duplicated. Scoreboard matches the concatenated frames.
- Write on the same edge as the last beat of the current frame -> both complete. dout_valid stays 1. New frame is read next with dout_idx=0.
- flush at beat 100 of frame 1 with frame 2 queued -> no dout_last, buff_empty=1, frames_sent unchanged. A new frame then streams correctly from bank 0.
- Assert nreset low at beat 50 -> all outputs at reset values immediately, without a clock edge. After release, a fresh frame serializes correctly.

Source files
------------

// File: rtl/ofdm_tx_frame_serializer.sv
// rtl/ofdm_tx_frame_serializer.sv - ping-pong frame buffer streaming FRAME_W words LSB-first in OUT_W-bit beats
module ofdm_tx_frame_serializer #(
    parameter  int FRAME_W = 224,
    parameter  int OUT_W   = 1,
    parameter  int CNT_W   = 16,
    localparam int BEATS   = FRAME_W / OUT_W,
    localparam int PTR_W   = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic [FRAME_W-1:0] din,
    input  logic               din_valid,
    output logic               din_ready,
    input  logic               flush,
    output logic [OUT_W-1:0]   dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               dout_last,
    output logic [PTR_W-1:0]   dout_idx,
    output logic               buff_full,
    output logic               buff_empty,
    output logic [CNT_W-1:0]   frames_sent
);

    logic [FRAME_W-1:0] bank0;
    logic [FRAME_W-1:0] bank1;
    logic [FRAME_W-1:0] rd_bank;
    logic [1:0]         full;
    logic [1:0]         full_nxt;
    logic               wr_sel;
    logic               rd_sel;
    logic [PTR_W-1:0]   rd_ptr;
    logic               wr_fire;
    logic               rd_fire;
    logic               rd_at_last;

    assign din_ready  = ~(full[0] & full[1]) & ~flush & nreset;
    assign wr_fire    = din_valid & din_ready;
    assign rd_at_last = (rd_ptr == PTR_W'(BEATS - 1));
    assign rd_fire    = dout_valid & dout_ready;

    // All stream outputs come from registered state; dout_ready only steers the next state.
    assign rd_bank    = rd_sel ? bank1 : bank0;
    assign dout       = rd_bank[rd_ptr*OUT_W +: OUT_W];
    assign dout_valid = full[rd_sel];
    assign dout_last  = dout_valid & rd_at_last;
    assign dout_idx   = rd_ptr;
    assign buff_full  = full[0] & full[1];
    assign buff_empty = ~(full[0] | full[1]);

    // A last-beat read and a write never hit the same bank: the write needs a free bank.
    always_comb begin
        full_nxt = full;
        if (rd_fire && rd_at_last) begin
            full_nxt[rd_sel] = 1'b0;
        end
        if (wr_fire) begin
            full_nxt[wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            bank0       <= '0;
            bank1       <= '0;
            full        <= '0;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            rd_ptr      <= '0;
            frames_sent <= '0;
        end else if (flush) begin
            bank0  <= '0;
            bank1  <= '0;
            full   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            rd_ptr <= '0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                if (wr_sel) begin
                    bank1 <= din;
                end else begin
                    bank0 <= din;
                end
                wr_sel <= ~wr_sel;
            end
            if (rd_fire) begin
                if (rd_at_last) begin
                    rd_ptr      <= '0;
                    rd_sel      <= ~rd_sel;
                    frames_sent <= frames_sent + 1'b1;
                end else begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ofdm_tx_frame_serializer.sv
// tb/tb_ofdm_tx_frame_serializer.sv - scoreboard bench for ofdm_tx_frame_serializer
module tb_ofdm_tx_frame_serializer;

    localparam int FRAME_W = 224;
    localparam int OUT_W   = 2;
    localparam int CNT_W   = 16;
    localparam int BEATS   = FRAME_W / OUT_W;
    localparam int PTR_W   = $clog2(BEATS);

    logic               clk = 1'b0;
    logic               nreset;
    logic [FRAME_W-1:0] din;
    logic               din_valid;
    logic               din_ready;
    logic               flush;
    logic [OUT_W-1:0]   dout;
    logic               dout_valid;
    logic               dout_ready;
    logic               dout_last;
    logic [PTR_W-1:0]   dout_idx;
    logic               buff_full;
    logic               buff_empty;
    logic [CNT_W-1:0]   frames_sent;

    ofdm_tx_frame_serializer #(.FRAME_W(FRAME_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .nreset(nreset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .flush(flush), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_last(dout_last), .dout_idx(dout_idx), .buff_full(buff_full),
        .buff_empty(buff_empty), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic [PTR_W-1:0] idx;
        logic             last;
    } beat_t;

    beat_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    bit    rnd_mode    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every accepted beat is popped and compared; stalled beats must hold.
    bit               have_prev = 0;
    logic [OUT_W-1:0] prev_dout;
    always @(negedge clk) begin
        if (nreset && !flush) begin
            if (have_prev && dout_valid) chk("stall_hold", dout, prev_dout);
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", dout, e.d);
                    chk("beat_idx", dout_idx, e.idx);
                    chk("beat_last", dout_last, e.last);
                end
            end
            have_prev = dout_valid && !dout_ready;
            prev_dout = dout;
        end else begin
            have_prev = 0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) dout_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_frame(input logic [FRAME_W-1:0] f);
        int n;
        beat_t e;
        n = 0;
        din       = f;
        din_valid = 1'b1;
        @(negedge clk);
        while (!din_ready && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (!din_ready) begin
            chk("din_ready_timeout", 0, 1);
        end else begin
            @(posedge clk);
            for (int i = 0; i < BEATS; i++) begin
                e.d    = f[i*OUT_W +: OUT_W];
                e.idx  = PTR_W'(i);
                e.last = (i == BEATS - 1);
                exp_q.push_back(e);
            end
            #1;
        end
        din_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        chk("drain_valid", dout_valid, 0);
        chk("drain_empty", buff_empty, 1);
    endtask

    task automatic wait_idx(input int idx);
        int n;
        n = 0;
        while (dout_idx != PTR_W'(idx) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_idx_timeout", dout_idx, idx);
    endtask

    initial begin
        logic [FRAME_W-1:0] fa, fb, fc, fx;
        int n;
        fa = 224'h0001_8000_0000_0005;
        fb = {7{32'hA5C3_0F96}};
        fc = {14{16'h3C71}};
        fx = {28{8'hE4}};

        nreset = 1'b0; din = '0; din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b0;
        #3;
        chk("rst_din_ready", din_ready, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout_last", dout_last, 0);
        chk("rst_dout_idx", dout_idx, 0);
        chk("rst_buff_full", buff_full, 0);
        chk("rst_buff_empty", buff_empty, 1);
        chk("rst_frames_sent", frames_sent, 0);
        @(posedge clk); #1 nreset = 1'b1;
        @(posedge clk); #1;
        chk("rel_din_ready", din_ready, 1);

        // Single frame, beat 0 = bits 1:0 of 0x5 = 2'b01.
        dout_ready = 1'b1;
        send_frame(fa);
        chk("load_valid", dout_valid, 1);
        chk("load_beat0", dout, 2'b01);
        chk("load_idx0", dout_idx, 0);
        drain();
        chk("fa_sent", frames_sent, 1);

        // Two frames fill both banks; third waits until a bank frees.
        dout_ready = 1'b0;
        send_frame(fb);
        send_frame(fc);
        chk("both_full", buff_full, 1);
        chk("full_din_ready", din_ready, 0);
        fork send_frame(fx); join_none
        repeat (5) @(posedge clk);
        #1;
        chk("held_din_ready", din_ready, 0);
        chk("held_idx", dout_idx, 0);
        dout_ready = 1'b1;
        n = 0;
        while (frames_sent != 16'd4 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("b2b_cycles", n, 3 * BEATS);
        drain();

        // Write lands on the same edge as the last beat of the current frame.
        send_frame(fb);
        wait_idx(BEATS - 1);
        send_frame(fx);
        chk("sim_valid", dout_valid, 1);
        chk("sim_idx", dout_idx, 0);
        chk("sim_sent", frames_sent, 5);
        chk("sim_full", buff_full, 0);
        drain();
        chk("sim_sent2", frames_sent, 6);

        // Random backpressure.
        rnd_mode = 1;
        send_frame(fc);
        send_frame(fa);
        send_frame(fb);
        drain();
        rnd_mode = 0;
        dout_ready = 1'b1;
        chk("rnd_sent", frames_sent, 9);

        // Flush mid-frame with the second bank loaded.
        send_frame(fx);
        send_frame(fc);
        wait_idx(100);
        flush = 1'b1;
        @(posedge clk);
        exp_q.delete();
        #1;
        chk("flush_valid", dout_valid, 0);
        chk("flush_empty", buff_empty, 1);
        chk("flush_din_ready", din_ready, 0);
        chk("flush_sent", frames_sent, 9);
        chk("flush_idx", dout_idx, 0);
        flush = 1'b0;
        #1;
        chk("postflush_ready", din_ready, 1);
        send_frame(fb);
        drain();
        chk("postflush_sent", frames_sent, 10);

        // Asynchronous reset mid-frame.
        send_frame(fc);
        wait_idx(50);
        #2 nreset = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_valid", dout_valid, 0);
        chk("arst_idx", dout_idx, 0);
        chk("arst_dout", dout, 0);
        chk("arst_sent", frames_sent, 0);
        chk("arst_empty", buff_empty, 1);
        chk("arst_din_ready", din_ready, 0);
        @(posedge clk); #1 nreset = 1'b1;
        @(posedge clk); #1;
        chk("arel_din_ready", din_ready, 1);
        send_frame(fa);
        drain();
        chk("arel_sent", frames_sent, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
